// File: rtl/seq_div_32_pkg.sv
// cpu_div_pkg: widths, counter width and FSM states shared by the divider files.
// No ports. neg_if() gives a two's-complement negate used by the sign correction
// in SEQ_DIV_SIGNED_EN builds.
package cpu_div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_div_32_if.sv
// seq_div_32_if: request/result bundle between a requester (master) and the divider (slave).
// Request: start, a (dividend), b (divisor), sign (only with SEQ_DIV_SIGNED_EN).
// Result: busy, done (1-cycle pulse), q, r, div_zero; q/r/div_zero hold until the next done.
interface seq_div_32_if;
  import cpu_div_pkg::*;

  logic             start;
  logic [DIV_W-1:0] a;
  logic [DIV_W-1:0] b;
`ifdef SEQ_DIV_SIGNED_EN
  logic             sign;
`endif
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] q;
  logic [DIV_W-1:0] r;
  logic             div_zero;

`ifdef SEQ_DIV_SIGNED_EN
  modport master (output start, a, b, sign, input busy, done, q, r, div_zero);
  modport slave  (input start, a, b, sign, output busy, done, q, r, div_zero);
`else
  modport master (output start, a, b, input busy, done, q, r, div_zero);
  modport slave  (input start, a, b, output busy, done, q, r, div_zero);
`endif

endinterface

// File: rtl/seq_div_32_sub_33.sv
// sub_33: 33-bit trial subtractor for the restoring divider.
// Combinational, zero latency, no backpressure.
// Ports: a_i - b_i -> diff_o (33-bit, modulo), borrow_o = 1 when b_i > a_i.
module sub_33
  import cpu_div_pkg::*;
(
  input  logic [DIV_W:0] a_i,
  input  logic [DIV_W:0] b_i,
  output logic [DIV_W:0] diff_o,
  output logic           borrow_o
);

  // Extending to 34 bits makes the top bit of the result the borrow.
  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/seq_div_32.sv
// seq_div_32: 32-bit sequential restoring divider, one quotient bit per cycle.
// Latency: start accepted in cycle N -> done in N+33 (N+1 when b == 0).
// Backpressure: none; start is only looked at in IDLE, ignored while busy or in DONE.
// Ports: clk, rst (sync, active high), div_if (slave side of seq_div_32_if).
// Optional macro SEQ_DIV_SIGNED_EN adds the sign input (truncate-toward-zero signed divide).
module seq_div_32
  import cpu_div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  seq_div_32_if.slave  div_if
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] rem_q;   // partial remainder
  logic [DIV_W-1:0] dvd_q;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [DIV_W-1:0] dvs_q;   // latched divisor (magnitude in signed mode)
  logic             busy_q;
  logic             done_q;
  logic [DIV_W-1:0] q_q;
  logic [DIV_W-1:0] r_q;
  logic             dz_q;
`ifdef SEQ_DIV_SIGNED_EN
  logic             negq_q;
  logic             negr_q;
`endif

  // Operand magnitudes presented at start.
  logic [DIV_W-1:0] a_mag;
  logic [DIV_W-1:0] b_mag;
`ifdef SEQ_DIV_SIGNED_EN
  assign a_mag = neg_if(div_if.a, div_if.sign & div_if.a[DIV_W-1]);
  assign b_mag = neg_if(div_if.b, div_if.sign & div_if.b[DIV_W-1]);
`else
  assign a_mag = div_if.a;
  assign b_mag = div_if.b;
`endif

  // One restoring step.
  logic [DIV_W:0]   trial_a;
  logic [DIV_W:0]   trial_b;
  logic [DIV_W:0]   diff;
  logic             borrow;
  logic             diff_msb_unused;
  logic [DIV_W-1:0] rem_d;
  logic [DIV_W-1:0] dvd_d;
  logic [DIV_W-1:0] q_fin;
  logic [DIV_W-1:0] r_fin;

  assign trial_a = {rem_q, dvd_q[DIV_W-1]};
  assign trial_b = {1'b0, dvs_q};

  sub_33 u_sub_33 (
    .a_i      (trial_a),
    .b_i      (trial_b),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // The remainder stays below the divisor, so a non-borrow difference always fits in 32 bits.
  assign diff_msb_unused = diff[DIV_W];

  always_comb begin
    rem_d = borrow ? trial_a[DIV_W-1:0] : diff[DIV_W-1:0];
    dvd_d = {dvd_q[DIV_W-2:0], ~borrow};
  end

  // Sign correction folds into the last CALC step so DONE comes no later.
`ifdef SEQ_DIV_SIGNED_EN
  assign q_fin = neg_if(dvd_d, negq_q);
  assign r_fin = neg_if(rem_d, negr_q);
`else
  assign q_fin = dvd_d;
  assign r_fin = rem_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (div_if.start) begin
            if (div_if.b == '0) begin
              // Divide by zero bypasses CALC; r reports the raw dividend.
              state_q <= DONE;
              done_q  <= 1'b1;
              q_q     <= '1;
              r_q     <= div_if.a;
              dz_q    <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              rem_q   <= '0;
              dvd_q   <= a_mag;
              dvs_q   <= b_mag;
`ifdef SEQ_DIV_SIGNED_EN
              negq_q  <= div_if.sign & (div_if.a[DIV_W-1] ^ div_if.b[DIV_W-1]);
              negr_q  <= div_if.sign & div_if.a[DIV_W-1];
`endif
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;   // wraps back to 0 on the last step
          if (cnt_q == CNT_W'(DIV_W - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            q_q     <= q_fin;
            r_q     <= r_fin;
            dz_q    <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.busy     = busy_q;
  assign div_if.done     = done_q;
  assign div_if.q        = q_q;
  assign div_if.r        = r_q;
  assign div_if.div_zero = dz_q;

endmodule

// File: tb/tb_seq_div_32.sv
// tb_seq_div_32: self-checking bench for seq_div_32 (directed vectors, ignored starts,
// reset behaviour, randomized operands vs. an arithmetic reference model).
// Signed scenarios are compiled in when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div_32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sign_unused;
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_div_32_if dif ();

  seq_div_32 dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain arithmetic on the requested operands.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF; r = a; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          q = 32'h80000000; r = 32'd0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Issues one request and waits (bounded) for done. lat = cycle index of done relative
  // to the accepting cycle N, 0 if done never came.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output int busy_cnt);
    @(posedge clk); #1;
    dif.start = 1'b1; dif.a = a; dif.b = b;
`ifdef SEQ_DIV_SIGNED_EN
    dif.sign = s;
`else
    sign_unused = s;
`endif
    @(posedge clk); #1;
    dif.start = 1'b0;
    dif.a = $urandom; dif.b = $urandom;   // operands must already be latched
    lat = 0; busy_cnt = 0;
    q = 'x; r = 'x; dz = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dif.busy) busy_cnt++;
      if (dif.done) begin
        lat = k; q = dif.q; r = dif.r; dz = dif.div_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    dif.start = 1'b1; dif.a = 32'd5; dif.b = 32'd0;
`ifdef SEQ_DIV_SIGNED_EN
    dif.sign = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", dif.busy); end
    n_cmp++; if (dif.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", dif.done); end
    n_cmp++; if (dif.q !== 32'd0) begin n_bad++; $display("FAIL reset_q: got %h want 0", dif.q); end
    n_cmp++; if (dif.r !== 32'd0) begin n_bad++; $display("FAIL reset_r: got %h want 0", dif.r); end
    n_cmp++; if (dif.div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dz: got %b want 0", dif.div_zero); end
    @(posedge clk); #1;
    rst = 1'b0; dif.start = 1'b0;
    @(negedge clk);
    n_cmp++; if (dif.done !== 1'b0) begin n_bad++; $display("FAIL rst_wins_done: got %b want 0", dif.done); end
    n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL rst_wins_busy: got %b want 0", dif.busy); end
  endtask

  task automatic test_directed();
    logic [31:0] aa [4] = '{32'd100, 32'hFFFFFFFF, 32'd5, 32'd1234};
    logic [31:0] bb [4] = '{32'd7,   32'd1,        32'd9, 32'd0};
    logic [31:0] eq [4] = '{32'd14,  32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [31:0] er [4] = '{32'd2,   32'd0,        32'd5, 32'd1234};
    logic [31:0] q, r;
    logic dz;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(aa[i], bb[i], 1'b0, q, r, dz, lat, bc);
      n_cmp++; if (lat !== ((bb[i] == 0) ? 1 : 33)) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, (bb[i] == 0) ? 1 : 33); end
      n_cmp++; if (bc !== ((bb[i] == 0) ? 0 : 32)) begin n_bad++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, (bb[i] == 0) ? 0 : 32); end
      n_cmp++; if (q !== eq[i]) begin n_bad++; $display("FAIL dir%0d_q: got %h want %h", i, q, eq[i]); end
      n_cmp++; if (r !== er[i]) begin n_bad++; $display("FAIL dir%0d_r: got %h want %h", i, r, er[i]); end
      n_cmp++; if (dz !== (bb[i] == 0)) begin n_bad++; $display("FAIL dir%0d_dz: got %b want %b", i, dz, bb[i] == 0); end
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0, done_at = 0, bc = 0;
    @(posedge clk); #1;
    dif.start = 1'b1; dif.a = 32'd100; dif.b = 32'd7;
`ifdef SEQ_DIV_SIGNED_EN
    dif.sign = 1'b0;
`endif
    @(posedge clk); #1;
    dif.start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (dif.busy) bc++;
      if (dif.done) begin done_cnt++; if (done_at == 0) done_at = k; end
      if (k == 10 || k == 33) begin dif.start = 1'b1; dif.a = 32'd50; dif.b = 32'd3; end
      if (k == 11 || k == 34) dif.start = 1'b0;
      if (k == 33) begin
        n_cmp++; if (dif.q !== 32'd14) begin n_bad++; $display("FAIL ign_q: got %h want 0000000e", dif.q); end
        n_cmp++; if (dif.r !== 32'd2) begin n_bad++; $display("FAIL ign_r: got %h want 00000002", dif.r); end
      end
      if (k == 45) begin
        n_cmp++; if (dif.q !== 32'd14) begin n_bad++; $display("FAIL hold_q: got %h want 0000000e", dif.q); end
        n_cmp++; if (dif.r !== 32'd2) begin n_bad++; $display("FAIL hold_r: got %h want 00000002", dif.r); end
        n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL hold_busy: got %b want 0", dif.busy); end
      end
    end
    n_cmp++; if (done_at !== 33) begin n_bad++; $display("FAIL ign_latency: got %0d want 33", done_at); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (bc !== 32) begin n_bad++; $display("FAIL ign_busy_cycles: got %0d want 32", bc); end
  endtask

  task automatic test_reset_mid_calc();
    int done_cnt = 0, lat, bc;
    logic [31:0] q, r, eq, er, ra, rb;
    logic dz, edz;
    @(posedge clk); #1;
    dif.start = 1'b1; dif.a = 32'd1000; dif.b = 32'd3;
`ifdef SEQ_DIV_SIGNED_EN
    dif.sign = 1'b0;
`endif
    @(posedge clk); #1;
    dif.start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k > 15 && dif.done) done_cnt++;
      if (k == 15) rst = 1'b1;
      if (k == 16) begin
        rst = 1'b0;
        n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", dif.busy); end
        n_cmp++; if (dif.q !== 32'd0) begin n_bad++; $display("FAIL midrst_q: got %h want 0", dif.q); end
        n_cmp++; if (dif.r !== 32'd0) begin n_bad++; $display("FAIL midrst_r: got %h want 0", dif.r); end
      end
    end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    ra = $urandom; rb = $urandom_range(1, 1000);
    ref_div(ra, rb, 1'b0, eq, er, edz);
    run_op(ra, rb, 1'b0, q, r, dz, lat, bc);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL after_rst_latency: got %0d want 33", lat); end
    n_cmp++; if (q !== eq || r !== er || dz !== edz) begin n_bad++; $display("FAIL after_rst_result: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", q, r, dz, eq, er, edz); end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, q, r, eq, er;
    logic dz, edz;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 16);
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      ref_div(ra, rb, 1'b0, eq, er, edz);
      run_op(ra, rb, 1'b0, q, r, dz, lat, bc);
      n_cmp++; if (lat !== ((rb == 0) ? 1 : 33)) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, (rb == 0) ? 1 : 33); end
      n_cmp++; if (q !== eq || r !== er || dz !== edz) begin n_bad++; $display("FAIL rnd%0d_result a=%h b=%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, ra, rb, q, r, dz, eq, er, edz); end
    end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    logic [31:0] aa [5] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFB2E, 32'hFFFFFFF9};
    logic [31:0] bb [5] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd2};
    logic        ss [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ra, rb, q, r, eq, er;
    logic dz, edz, rs;
    int lat, bc;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) begin ra = aa[i]; rb = bb[i]; rs = ss[i]; end
      else begin ra = $urandom; rb = (i % 5 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28)); rs = $urandom_range(0, 1); end
      if (rb != 0 && i >= 5 && (i % 2 == 1)) rb = ~rb + 1;
      ref_div(ra, rb, rs, eq, er, edz);
      run_op(ra, rb, rs, q, r, dz, lat, bc);
      n_cmp++; if (lat !== ((rb == 0) ? 1 : 33)) begin n_bad++; $display("FAIL sgn%0d_latency: got %0d want %0d", i, lat, (rb == 0) ? 1 : 33); end
      n_cmp++; if (q !== eq || r !== er || dz !== edz) begin n_bad++; $display("FAIL sgn%0d_result a=%h b=%h s=%b: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, ra, rb, rs, q, r, dz, eq, er, edz); end
    end
  endtask
`endif

  initial begin
    dif.start = 1'b0; dif.a = '0; dif.b = '0;
    sign_unused = 1'b0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_calc();
    test_random();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
